// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag layout for alu_pipe and alu_core.
package alu_pkg;

    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op, a, b -> y, {n,z,c,v}.
// Define ALU_SAT_EN to make add/sub saturate (carry/borrow still reported unclamped).
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]        op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic [WIDTH-1:0]  y_o,
    output logic [FLAG_W-1:0] flags_o
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] shl_ext;
    logic [WIDTH:0] shr_ext;
    logic           c;
    logic           v;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    // One guard bit on the outgoing side captures the last bit shifted out;
    // shifts past WIDTH+1 naturally leave both result and guard at zero.
    assign shl_ext = {1'b0, a_i} << b_i;
    assign shr_ext = {a_i, 1'b0} >> b_i;

    always_comb begin
        y_o = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op_i)
            OP_ADD: begin
                y_o = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
`ifdef ALU_SAT_EN
                if (c) y_o = '1;
`endif
            end
            OP_SUB: begin
                y_o = diff[MSB:0];
                c   = diff[WIDTH];
                v   = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
`ifdef ALU_SAT_EN
                if (c) y_o = '0;
`endif
            end
            OP_XOR:  y_o = a_i ^ b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_SHL: begin
                y_o = shl_ext[MSB:0];
                c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                y_o = shr_ext[WIDTH:1];
                c   = shr_ext[0];
            end
        endcase
    end

    always_comb begin
        flags_o        = '0;
        flags_o[FLG_N] = y_o[MSB];
        flags_o[FLG_Z] = (y_o == '0);
        flags_o[FLG_C] = c;
        flags_o[FLG_V] = v;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline around alu_core (saturation via ALU_SAT_EN).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_y,
    output logic [FLAG_W-1:0] out_flags
);

    logic              s1_valid_q, s1_valid_d;
    logic [2:0]        s1_op_q,    s1_op_d;
    logic [WIDTH-1:0]  s1_a_q,     s1_a_d;
    logic [WIDTH-1:0]  s1_b_q,     s1_b_d;
    logic              s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  s2_y_q,     s2_y_d;
    logic [FLAG_W-1:0] s2_flags_q, s2_flags_d;

    logic              s2_adv;
    logic              s1_adv;
    logic              in_fire;
    logic [WIDTH-1:0]  core_y;
    logic [FLAG_W-1:0] core_flags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i    (s1_op_q),
        .a_i     (s1_a_q),
        .b_i     (s1_b_q),
        .y_o     (core_y),
        .flags_o (core_flags)
    );

    // in_ready is combinational from out_ready: no skid storage behind S1.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_flags_d = s2_flags_q;
        if (in_ready) s1_valid_d = in_valid;
        if (in_fire) begin
            s1_op_d = in_op;
            s1_a_d  = in_a;
            s1_b_d  = in_b;
        end
        if (s2_adv) s2_valid_d = s1_valid_q;
        if (s1_adv) begin
            s2_y_d     = core_y;
            s2_flags_d = core_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_y     = s2_y_q;
    assign out_flags = s2_flags_q;

endmodule
